hwag_cap_filter: RTL and testbench

Crank-sensor front end placed directly upstream of `hwag_core`. It conditions the raw VR comparator signal: a 2-FF synchronizer, a programmable-length glitch filter, active-edge selection, and adaptive blanking that rejects active edges arriving too soon after the previous one. It drives `hwag_core.cap` with a clean level, emits a one-cycle strobe per accepted tooth edge, and measures the tooth period in clock cycles.

---
 rtl/hwag_pkg.sv | 13 +
 rtl/hwag_cap_filter_if.sv | 30 +++
 rtl/hwag_glitch_filt.sv | 50 +++++
 rtl/hwag_cap_filter.sv | 127 ++++++++++++
 tb/tb_hwag_cap_filter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hwag_pkg.sv
// Shared crank-capture definitions used by hwag_cap_filter and hwag_core.
// Edge-select encoding, default blanking shift and reject counter width.
package hwag_pkg;

    localparam int HWAG_BLANK_SHIFT = 2;
    localparam int HWAG_REJ_W       = 8;

    typedef enum logic {
        HWAG_EDGE_FALL = 1'b0,
        HWAG_EDGE_RISE = 1'b1
    } hwag_edge_e;

endpackage

// File: rtl/hwag_cap_filter_if.sv
// Signal bundle between the crank-sensor front end and its controller / hwag_core.
// master drives configuration and the raw comparator; slave is the filter.
interface hwag_cap_filter_if #(
    parameter int FILT_W = 4,
    parameter int PER_W  = 24
);
    import hwag_pkg::*;

    logic                  ena;
    logic                  cap_in;
    logic                  cap_edge_sel;
    logic [FILT_W-1:0]     filt_len;
    logic                  cap_out;
    logic                  cap_stb;
    logic [PER_W-1:0]      period;
    logic                  period_vld;
    logic [HWAG_REJ_W-1:0] rej_cnt;
    logic                  ovf;

    modport master (
        output ena, cap_in, cap_edge_sel, filt_len,
        input  cap_out, cap_stb, period, period_vld, rej_cnt, ovf
    );

    modport slave (
        input  ena, cap_in, cap_edge_sel, filt_len,
        output cap_out, cap_stb, period, period_vld, rej_cnt, ovf
    );

endinterface

// File: rtl/hwag_glitch_filt.sv
// 2-FF synchronizer plus programmable glitch filter for the raw VR comparator.
// filt flips only after the synchronized input disagrees for filt_len+1 cycles.
module hwag_glitch_filt #(
    parameter int FILT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              filt
);

    logic              s1_reg;
    logic              s2_reg;
    logic              filt_reg;
    logic [FILT_W-1:0] fcnt_reg;

    // The synchronizer keeps running while disabled so the first enabled
    // cycle already sees a settled input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= cap_in;
            s2_reg <= s1_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt_reg <= '0;
            filt_reg <= 1'b0;
        end else if (!ena) begin
            fcnt_reg <= '0;
            filt_reg <= 1'b0;
        end else if (s2_reg == filt_reg) begin
            fcnt_reg <= '0;
        end else if (fcnt_reg == filt_len) begin
            filt_reg <= s2_reg;
            fcnt_reg <= '0;
        end else begin
            fcnt_reg <= fcnt_reg + FILT_W'(1);
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/hwag_cap_filter.sv
// Crank-sensor front end: glitch filter, active-edge select, adaptive blanking
// and tooth-period measurement. Blanking is compiled in with HWAG_CAP_BLANK_EN.
module hwag_cap_filter
    import hwag_pkg::*;
#(
    parameter int FILT_W      = 4,
    parameter int PER_W       = 24,
    parameter int BLANK_SHIFT = HWAG_BLANK_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    hwag_cap_filter_if.slave   bus
);

    localparam logic [PER_W-1:0] PER_MAX = '1;

`ifdef HWAG_CAP_BLANK_EN
    localparam bit BLANK_BYPASS = 1'b0;
`else
    localparam bit BLANK_BYPASS = 1'b1;
`endif

    logic                  filt;
    logic                  filt_q_reg;
    logic                  cap_out_reg;
    logic                  cap_stb_reg;
    logic [PER_W-1:0]      period_reg;
    logic                  period_vld_reg;
    logic [PER_W-1:0]      pcnt_reg;
    logic                  ovf_reg;
    logic [HWAG_REJ_W-1:0] rej_cnt_reg;

    hwag_edge_e            edge_sel;
    logic                  active_lvl;
    logic                  filt_chg;
    logic                  act_edge;
    logic                  inact_edge;
    logic                  has_ref;
    logic                  blank_ok;
    logic                  accept;
    logic                  reject;

    hwag_glitch_filt #(
        .FILT_W (FILT_W)
    ) u_glitch_filt (
        .clk      (clk),
        .rst      (rst),
        .ena      (bus.ena),
        .cap_in   (bus.cap_in),
        .filt_len (bus.filt_len),
        .filt     (filt)
    );

    assign edge_sel   = hwag_edge_e'(bus.cap_edge_sel);
    assign active_lvl = (edge_sel == HWAG_EDGE_RISE);
    assign filt_chg   = filt ^ filt_q_reg;
    assign act_edge   = filt_chg && (filt == active_lvl);
    assign inact_edge = filt_chg && (filt != active_lvl);

    // pcnt stays at zero until the first accepted edge after reset/enable:
    // there is no reference edge yet, so that edge cannot yield a period.
    assign has_ref  = (pcnt_reg != '0);
    assign blank_ok = !period_vld_reg || (pcnt_reg >= (period_reg >> BLANK_SHIFT));
    assign accept   = act_edge && (BLANK_BYPASS || blank_ok);
    assign reject   = act_edge && !accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q_reg     <= 1'b0;
            cap_out_reg    <= 1'b0;
            cap_stb_reg    <= 1'b0;
            period_reg     <= '0;
            period_vld_reg <= 1'b0;
            pcnt_reg       <= '0;
            ovf_reg        <= 1'b0;
            rej_cnt_reg    <= '0;
        end else if (!bus.ena) begin
            filt_q_reg     <= 1'b0;
            cap_out_reg    <= 1'b0;
            cap_stb_reg    <= 1'b0;
            period_reg     <= '0;
            period_vld_reg <= 1'b0;
            pcnt_reg       <= '0;
            ovf_reg        <= 1'b0;
            rej_cnt_reg    <= '0;
        end else begin
            filt_q_reg  <= filt;
            cap_stb_reg <= accept;
            if (accept) begin
                cap_out_reg <= active_lvl;
                pcnt_reg    <= PER_W'(1);
                ovf_reg     <= 1'b0;
                // A saturated count is not a period; drop validity so the
                // following edge is never blanked against stale data.
                if (has_ref) begin
                    if (ovf_reg) begin
                        period_vld_reg <= 1'b0;
                    end else begin
                        period_reg     <= pcnt_reg;
                        period_vld_reg <= 1'b1;
                    end
                end
            end else begin
                if (inact_edge && (cap_out_reg == active_lvl)) begin
                    cap_out_reg <= ~active_lvl;
                end
                if (has_ref && (pcnt_reg != PER_MAX)) begin
                    pcnt_reg <= pcnt_reg + PER_W'(1);
                    if (pcnt_reg == PER_MAX - PER_W'(1)) begin
                        ovf_reg <= 1'b1;
                    end
                end
                if (reject && (rej_cnt_reg != '1)) begin
                    rej_cnt_reg <= rej_cnt_reg + HWAG_REJ_W'(1);
                end
            end
        end
    end

    assign bus.cap_out    = cap_out_reg;
    assign bus.cap_stb    = cap_stb_reg;
    assign bus.period     = period_reg;
    assign bus.period_vld = period_vld_reg;
    assign bus.rej_cnt    = rej_cnt_reg;
    assign bus.ovf        = ovf_reg;

endmodule

// File: tb/tb_hwag_cap_filter.sv
// Scoreboard bench for hwag_cap_filter: run-length stimulus feeds an event-level
// reference model; a monitor checks every strobe and cap_out change.
module tb_hwag_cap_filter;
    import hwag_pkg::*;

    localparam int FILT_W = 4;
    localparam int PER_W  = 8;
    localparam int PMAX   = 255;
    localparam int BS     = HWAG_BLANK_SHIFT;
`ifdef HWAG_CAP_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hwag_cap_filter_if #(.FILT_W(FILT_W), .PER_W(PER_W)) bus ();

    hwag_cap_filter #(
        .FILT_W      (FILT_W),
        .PER_W       (PER_W),
        .BLANK_SHIFT (BS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct { int cyc; int period; bit vld; int rej; } stb_t;
    typedef struct { int cyc; bit lvl; } lvl_t;
    stb_t stb_q[$];
    lvl_t lvl_q[$];

    // Reference model state, expressed in filtered-edge events.
    bit m_filt, m_sel, m_cap_out, m_vld, m_has_ref;
    int m_period, m_rej, m_last, m_flen;
    bit run_lvl, run_flipped;
    int run_start;
    int n_exp = 0;
    int n_seen = 0;

    function automatic void model_reset();
        m_filt = 0; m_cap_out = 0; m_vld = 0; m_has_ref = 0;
        m_period = 0; m_rej = 0; m_last = 0;
        run_lvl = 0; run_flipped = 0; run_start = 0;
    endfunction

    // Filtered level v appears on the outputs at edge e.
    function automatic void process_flip(int e, bit v);
        int d, pc;
        bit acc;
        if (v == m_sel) begin
            d   = m_has_ref ? e - m_last : 0;
            pc  = (d > PMAX) ? PMAX : d;
            acc = !BLANK_EN || !m_vld || (pc >= (m_period >> BS));
            if (acc) begin
                if (m_has_ref) begin
                    if (d >= PMAX) m_vld = 0;
                    else begin m_period = d; m_vld = 1; end
                end
                m_has_ref = 1;
                m_last = e;
                if (m_cap_out != v) begin
                    lvl_q.push_back('{e, v});
                    m_cap_out = v;
                end
                stb_q.push_back('{e, m_period, m_vld, m_rej});
                n_exp++;
            end else if (m_rej < 255) begin
                m_rej++;
            end
        end else if (m_cap_out == m_sel) begin
            m_cap_out = !m_sel;
            lvl_q.push_back('{e, m_cap_out});
        end
    endfunction

    // Hold cap_in at lvl for len sampling edges; consecutive equal levels merge.
    task automatic drive(input bit lvl, input int len);
        int k, so_far;
        @(posedge clk); #1;
        bus.cap_in = lvl;
        k = cyc + 1;
        if (lvl != run_lvl) begin
            run_lvl = lvl; run_start = k; run_flipped = 0;
        end
        so_far = k + len - run_start;
        if (!run_flipped && lvl != m_filt && so_far >= m_flen + 1) begin
            run_flipped = 1;
            m_filt = lvl;
            process_flip(run_start + m_flen + 3, lvl);
        end
        repeat (len - 1) @(posedge clk);
    endtask

    task automatic set_sel(input bit v);
        drive(run_lvl, 10);
        bus.cap_edge_sel = v;
        m_sel = v;
    endtask

    // Monitor: consumes expectations whenever the DUT strobes or moves cap_out.
    bit last_cap_out = 1'b0;
    always @(negedge clk) begin
        stb_t s;
        lvl_t l;
        if (bus.cap_stb) begin
            n_seen++;
            if (stb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_stb: actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                s = stb_q.pop_front();
                chk("stb_cycle", cyc, s.cyc);
                chk("stb_period", bus.period, s.period);
                chk("stb_period_vld", bus.period_vld, s.vld);
                chk("stb_rej_cnt", bus.rej_cnt, s.rej);
                chk("stb_ovf", bus.ovf, 0);
            end
        end
        if (bus.cap_out != last_cap_out) begin
            last_cap_out = bus.cap_out;
            if (lvl_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_cap_out: actual=%0d at cycle %0d", bus.cap_out, cyc);
            end else begin
                l = lvl_q.pop_front();
                chk("cap_out_cycle", cyc, l.cyc);
                chk("cap_out_level", bus.cap_out, l.lvl);
            end
        end
    end

    initial begin
        int lvl, len, r, n0;
        bus.ena = 1'b1;
        bus.cap_in = 1'b0;
        bus.cap_edge_sel = HWAG_EDGE_RISE;
        bus.filt_len = 4'd3;
        m_sel = 1; m_flen = 3;
        model_reset();

        repeat (3) @(posedge clk); #1;
        chk("rst_cap_out", bus.cap_out, 0);
        chk("rst_cap_stb", bus.cap_stb, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_period_vld", bus.period_vld, 0);
        chk("rst_rej_cnt", bus.rej_cnt, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst = 1'b1;

        // First edge after reset: strobe filt_len+3 later, no valid period.
        drive(1, 20); drive(0, 20);
        n0 = n_seen;
        drive(1, 3); drive(0, 20);
        chk("glitch3_cap_out", bus.cap_out, 0);
        chk("glitch3_no_stb", n_seen, n0);
        drive(1, 5); drive(0, 20);

        for (int i = 0; i < 3; i++) begin drive(1, 50); drive(0, 50); end
        chk("period_100", bus.period, 100);
        chk("period_100_vld", bus.period_vld, 1);

        // Active edges 20 and 30 cycles after a strobe with period 100.
        drive(1, 10); drive(0, 10); drive(1, 5); drive(0, 5); drive(1, 20); drive(0, 20);
        chk("blank_period", bus.period, BLANK_EN ? 30 : 10);
        chk("blank_rej_cnt", bus.rej_cnt, BLANK_EN ? 1 : 0);

        set_sel(HWAG_EDGE_FALL);
        drive(1, 40); drive(0, 40); drive(1, 40); drive(0, 40);
        chk("fall_period", bus.period, 80);

        set_sel(HWAG_EDGE_RISE);
        drive(1, 10); drive(0, 300);
        chk("stall_ovf", bus.ovf, 1);
        drive(1, 10); drive(0, 10); drive(1, 10); drive(0, 20);
        chk("stall_recover_period", bus.period, 20);
        chk("stall_recover_vld", bus.period_vld, 1);

        // Synchronous disable.
        @(posedge clk); #1;
        bus.ena = 1'b0;
        if (m_cap_out) lvl_q.push_back('{cyc + 1, 1'b0});
        repeat (2) @(posedge clk); #1;
        chk("ena_period", bus.period, 0);
        chk("ena_period_vld", bus.period_vld, 0);
        chk("ena_cap_out", bus.cap_out, 0);
        bus.ena = 1'b1;
        model_reset();
        drive(1, 20); drive(0, 20);

        // Asynchronous reset while the filter counter is at 2.
        drive(1, 30); drive(0, 30); drive(1, 30);
        @(posedge clk); #1;
        bus.cap_in = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        if (m_cap_out) lvl_q.push_back('{cyc, 1'b0});
        #1;
        chk("arst_cap_out", bus.cap_out, 0);
        chk("arst_period", bus.period, 0);
        chk("arst_period_vld", bus.period_vld, 0);
        chk("arst_ovf", bus.ovf, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        drive(1, 20); drive(0, 20);

        // Randomized run lengths with a random filter length.
        m_flen = $urandom_range(0, 4);
        bus.filt_len = FILT_W'(m_flen);
        lvl = 1;
        for (int i = 0; i < 160; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      len = $urandom_range(1, (m_flen > 0) ? m_flen : 1);
            else if (r < 85) len = $urandom_range(m_flen + 1, 60);
            else if (r < 95) len = $urandom_range(60, 160);
            else             len = $urandom_range(250, 300);
            drive(lvl[0], len);
            lvl = 1 - lvl;
            if (i % 50 == 49) set_sel(1'($urandom_range(0, 1)));
        end
        drive(run_lvl, 40);

        chk("stb_count", n_seen, n_exp);
        chk("final_rej_cnt", bus.rej_cnt, m_rej);
        chk("stb_q_empty", stb_q.size(), 0);
        chk("lvl_q_empty", lvl_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
